alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: number of result-buffer entries; power of two, minimum 2.
REQ-002 Port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port i_cmd_valid  input  1  command offered.
REQ-005 Port o_cmd_ready  output  1  command accepted when valid and ready are both high at a clock edge.
REQ-006 Port i_cmd_a  input  8  operand A.
REQ-007 Port i_cmd_b  input  8  operand B.
REQ-008 Port i_cmd_op  input  2  opcode: 0 XOR, 1 A*B+A+~B, 2 pass A, 3 pass B.
REQ-009 Port o_alu_a  output  8  registered operand A driven to the ALU.
REQ-010 Port o_alu_b  output  8  registered operand B driven to the ALU.
REQ-011 Port o_alu_control  output  2  registered opcode driven to the ALU.
REQ-012 Port i_alu_out  input  17  combinational ALU result.
REQ-013 Port o_res_valid  output  1  result-buffer head is valid.
REQ-014 Port i_res_ready  input  1  consumer pops the head when valid and ready are both high at a clock edge.
REQ-015 Port o_res_data  output  17  head result.
REQ-016 Port o_res_tag  output  8  head tag (command sequence number).
REQ-017 Port o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 Port o_mismatch  output  1  sticky result-check error flag.

Function
REQ-019 FSM states SHALL be IDLE, DRIVE and CAPTURE.
REQ-020 IDLE->DRIVE on accept; DRIVE->CAPTURE unconditionally; CAPTURE->IDLE unconditionally.
REQ-021 o_cmd_ready SHALL be high only in IDLE with buffer count < FIFO_DEPTH; one command in flight at most.
REQ-022 On accept, operands, opcode and the current tag SHALL be registered onto o_alu_* (visible in DRIVE); o_alu_* hold their values until the next accept.
REQ-023 In CAPTURE, i_alu_out and the tag SHALL be pushed into the buffer; o_res_valid rises the next cycle (accept-to-valid latency 3 cycles).
REQ-024 The tag counter SHALL increment by 1 per accepted command, wrapping 255->0.
REQ-025 The buffer SHALL be FIFO-ordered; a simultaneous push and pop SHALL both take effect and leave the count unchanged.
REQ-026 o_res_data and o_res_tag SHALL hold stable while o_res_valid is high and i_res_ready is low.
REQ-027 A pop on an empty buffer SHALL be ignored; a push cannot occur on a full buffer (guaranteed by REQ-021).
REQ-028 Next accept SHALL be possible in the cycle after CAPTURE: peak throughput is one command per 3 cycles.

Reset
REQ-029 While i_rst_n is low: state IDLE, tag 0, buffer empty, o_alu_a/o_alu_b/o_alu_control 0, o_res_valid 0, o_res_data 0, o_res_tag 0, o_busy 0, o_mismatch 0, o_cmd_ready 0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight command and all buffered results; o_cmd_ready rises the first cycle after release.

Configuration
REQ-031 With ALU_SEQ_CHECK_EN defined: in CAPTURE, a 17-bit expected result is computed (XOR and passes zero-extended; op 1 as A*B+A+(~B & 8'hFF) in 17 bits); any difference from i_alu_out sets o_mismatch until reset.
REQ-032 Without ALU_SEQ_CHECK_EN: no checker logic; o_mismatch is tied to 0.

Structure
REQ-033 Shared package alu_seq_pkg SHALL hold the opcode constants (OP_XOR, OP_MULADD, OP_PASS_A, OP_PASS_B), the FSM state type, and the widths (8, 17, tag 8).
REQ-034 The result buffer SHALL be the sub-module alu_seq_fifo (width 25: data plus tag, parameter FIFO_DEPTH); the remaining logic stays in alu_sequencer.

Verification
REQ-035 Op 0, A=0xF0, B=0x3C, ALU model attached -> o_res_data=0x000CC, tag 0, o_res_valid 3 cycles after accept.
REQ-036 Op 1, A=3, B=5 -> 0x0010C; op 1, A=0xFF, B=0xFF -> 0x0FF00; ops 2 and 3 with A=0x5A, B=0xA5 -> 0x0005A and 0x000A5.
REQ-037 i_res_ready held low, 3 commands offered -> 2 accepted, o_cmd_ready low afterwards; one pop -> third command accepted; results returned in order with tags 0, 1, 2.
REQ-038 256+1 commands with i_res_ready high -> tags run 0..255 and then 0.
REQ-039 i_rst_n pulsed low during DRIVE with 1 result buffered -> o_res_valid 0 and tag 0 after release; next result carries tag 0.
REQ-040 ALU_SEQ_CHECK_EN defined, i_alu_out forced to 0x00000 for op 2 with A=0x01 -> o_mismatch 1 and it stays 1 through later correct results until reset.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, widths, FSM states,
// result-buffer entry layout and the reference result used by the optional checker.
package alu_seq_pkg;

    localparam int OPND_W  = 8;
    localparam int RES_W   = 17;
    localparam int TAG_W   = 8;
    localparam int ENTRY_W = RES_W + TAG_W;

    localparam logic [1:0] OP_XOR    = 2'd0;
    localparam logic [1:0] OP_MULADD = 2'd1;
    localparam logic [1:0] OP_PASS_A = 2'd2;
    localparam logic [1:0] OP_PASS_B = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } res_entry_t;

    function automatic logic [RES_W-1:0] expected_result(
        input logic [1:0]        op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        logic [RES_W-1:0] a_ext;
        logic [RES_W-1:0] b_ext;
        logic [RES_W-1:0] nb_ext;
        logic [RES_W-1:0] r;
        a_ext  = {{(RES_W-OPND_W){1'b0}}, a};
        b_ext  = {{(RES_W-OPND_W){1'b0}}, b};
        nb_ext = {{(RES_W-OPND_W){1'b0}}, ~b};
        case (op)
            OP_XOR:    r = a_ext ^ b_ext;
            // Max 255*255+255+255 = 65535, so 17 bits never overflow.
            OP_MULADD: r = a_ext * b_ext + a_ext + nb_ext;
            OP_PASS_A: r = a_ext;
            default:   r = b_ext;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command / ALU / result / status bundle of the ALU sequencer.
// slave is the sequencer side, master is the command source, ALU and result consumer.
interface alu_sequencer_if;

    logic                             i_cmd_valid;
    logic                             o_cmd_ready;
    logic [alu_seq_pkg::OPND_W-1:0]   i_cmd_a;
    logic [alu_seq_pkg::OPND_W-1:0]   i_cmd_b;
    logic [1:0]                       i_cmd_op;

    logic [alu_seq_pkg::OPND_W-1:0]   o_alu_a;
    logic [alu_seq_pkg::OPND_W-1:0]   o_alu_b;
    logic [1:0]                       o_alu_control;
    logic [alu_seq_pkg::RES_W-1:0]    i_alu_out;

    logic                             o_res_valid;
    logic                             i_res_ready;
    logic [alu_seq_pkg::RES_W-1:0]    o_res_data;
    logic [alu_seq_pkg::TAG_W-1:0]    o_res_tag;

    logic                             o_busy;
    logic                             o_mismatch;

    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_alu_out, i_res_ready,
        output o_cmd_ready, o_alu_a, o_alu_b, o_alu_control,
        output o_res_valid, o_res_data, o_res_tag, o_busy, o_mismatch
    );

    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_alu_out, i_res_ready,
        input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_control,
        input  o_res_valid, o_res_data, o_res_tag, o_busy, o_mismatch
    );

endinterface

// File: rtl/alu_seq_fifo.sv
// Result buffer: DEPTH-entry FIFO (power of two), head visible the cycle after push.
// Pops on empty are ignored; pushes on full are dropped; push+pop together keep the count.
module alu_seq_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_vld,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_en;
    logic             pop_en;

    assign o_vld      = (count_q != '0);
    assign o_full     = (count_q == (PTR_W+1)'(DEPTH));
    assign push_en    = i_push && !o_full;
    assign pop_en     = i_pop && o_vld;
    assign o_head_dat = mem_q[rd_ptr_q];

    // Storage is reset too so the head reads zero straight out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= i_push_dat;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external ALU (IDLE->DRIVE->CAPTURE), accept-to-result 3 cycles;
// ready drops while busy or the result buffer is full. ALU_SEQ_CHECK_EN adds a sticky result checker.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    alu_sequencer_if.slave bus
);

    state_t              state_q;
    state_t              state_d;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    tag_d;
    logic [TAG_W-1:0]    fl_tag_q;
    logic [TAG_W-1:0]    fl_tag_d;
    logic [OPND_W-1:0]   alu_a_q;
    logic [OPND_W-1:0]   alu_a_d;
    logic [OPND_W-1:0]   alu_b_q;
    logic [OPND_W-1:0]   alu_b_d;
    logic [1:0]          alu_ctrl_q;
    logic [1:0]          alu_ctrl_d;
    logic                run_q;

    logic                accept;
    logic                push;
    logic                fifo_full;
    logic                fifo_vld;
    res_entry_t          push_dat;
    res_entry_t          head_dat;

    // run_q keeps ready low during reset and lets it rise on the first edge after release.
    assign bus.o_cmd_ready = run_q && (state_q == IDLE) && !fifo_full;
    assign accept          = bus.i_cmd_valid && bus.o_cmd_ready;

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        fl_tag_d   = fl_tag_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = DRIVE;
                    alu_a_d    = bus.i_cmd_a;
                    alu_b_d    = bus.i_cmd_b;
                    alu_ctrl_d = bus.i_cmd_op;
                    fl_tag_d   = tag_q;
                    tag_d      = tag_q + TAG_W'(1);
                end
            end
            DRIVE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
                push    = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            fl_tag_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            fl_tag_q   <= fl_tag_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            run_q      <= 1'b1;
        end
    end

    assign push_dat.data = bus.i_alu_out;
    assign push_dat.tag  = fl_tag_q;

    alu_seq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (push),
        .i_push_dat (push_dat),
        .i_pop      (bus.i_res_ready),
        .o_head_dat (head_dat),
        .o_vld      (fifo_vld),
        .o_full     (fifo_full)
    );

    assign bus.o_alu_a       = alu_a_q;
    assign bus.o_alu_b       = alu_b_q;
    assign bus.o_alu_control = alu_ctrl_q;
    assign bus.o_res_valid   = fifo_vld;
    assign bus.o_res_data    = head_dat.data;
    assign bus.o_res_tag     = head_dat.tag;
    assign bus.o_busy        = (state_q != IDLE);

`ifdef ALU_SEQ_CHECK_EN
    logic mismatch_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mismatch_q <= 1'b0;
        end else if ((state_q == CAPTURE) &&
                     (bus.i_alu_out != expected_result(alu_ctrl_q, alu_a_q, alu_b_q))) begin
            mismatch_q <= 1'b1;
        end
    end

    assign bus.o_mismatch = mismatch_q;
`else
    assign bus.o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with an attached behavioural ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [16:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic force_bad;
    int   total = 0;
    int   bad   = 0;

    alu_sequencer_if bus();

    alu_sequencer #(.FIFO_DEPTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] nb;
        nb = ~b;
        case (op)
            2'd0:    return {9'd0, a ^ b};
            2'd1:    return {9'd0, a} * {9'd0, b} + {9'd0, a} + {9'd0, nb};
            2'd2:    return {9'd0, a};
            default: return {9'd0, b};
        endcase
    endfunction

    always_comb begin
        bus.i_alu_out = force_bad ? 17'd0 : alu_model(bus.o_alu_control, bus.o_alu_a, bus.o_alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int budget, output bit ok);
        ok = 1'b0;
        bus.i_cmd_op    = op;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
        bus.i_cmd_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (bus.o_cmd_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.i_cmd_valid = 1'b0;
    endtask

    // Called just after the accepting edge; counts that edge as cycle 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.o_res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] exp_tag);
        bit ok;
        int lat;
        send(v.op, v.a, v.b, 10, ok);
        chk("vec_accept", 32'(ok), 32'd1);
        chk("vec_busy_drive", 32'(bus.o_busy), 32'd1);
        chk("vec_alu_a", 32'(bus.o_alu_a), 32'(v.a));
        chk("vec_alu_b", 32'(bus.o_alu_b), 32'(v.b));
        chk("vec_alu_ctrl", 32'(bus.o_alu_control), 32'(v.op));
        wait_valid(lat);
        chk("vec_latency", 32'(lat), 32'd3);
        chk("vec_data", 32'(bus.o_res_data), 32'(v.exp));
        chk("vec_tag", 32'(bus.o_res_tag), 32'(exp_tag));
        chk("vec_alu_a_hold", 32'(bus.o_alu_a), 32'(v.a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        bit   ok;
        int   lat;

        vecs[0] = '{op: 2'd0, a: 8'hF0, b: 8'h3C, exp: 17'h000CC};
        vecs[1] = '{op: 2'd1, a: 8'h03, b: 8'h05, exp: 17'h0010C};
        vecs[2] = '{op: 2'd1, a: 8'hFF, b: 8'hFF, exp: 17'h0FF00};
        vecs[3] = '{op: 2'd2, a: 8'h5A, b: 8'hA5, exp: 17'h0005A};
        vecs[4] = '{op: 2'd3, a: 8'h5A, b: 8'hA5, exp: 17'h000A5};

        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = 8'h00;
        bus.i_cmd_b     = 8'h00;
        bus.i_cmd_op    = 2'd0;
        bus.i_res_ready = 1'b0;
        force_bad       = 1'b0;
        rst_n           = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.o_res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.o_res_data), 32'd0);
        chk("rst_res_tag", 32'(bus.o_res_tag), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_mismatch", 32'(bus.o_mismatch), 32'd0);
        chk("rst_alu_a", 32'(bus.o_alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.o_alu_b), 32'd0);
        chk("rst_alu_ctrl", 32'(bus.o_alu_control), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(bus.o_cmd_ready), 32'd1);

        // Opcode table, consumer always ready
        bus.i_res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 8'(i));
        end
        @(posedge clk); #1;

        // Backpressure: two entries fill the buffer, third waits for a pop
        do_reset();
        bus.i_res_ready = 1'b0;
        send(OP_XOR, 8'h01, 8'h02, 10, ok);
        chk("bp_accept0", 32'(ok), 32'd1);
        send(OP_PASS_A, 8'h11, 8'h00, 10, ok);
        chk("bp_accept1", 32'(ok), 32'd1);
        repeat (4) begin @(posedge clk); #1; end
        chk("bp_full_valid", 32'(bus.o_res_valid), 32'd1);
        chk("bp_full_ready", 32'(bus.o_cmd_ready), 32'd0);
        send(OP_PASS_B, 8'h00, 8'h33, 8, ok);
        chk("bp_third_blocked", 32'(ok), 32'd0);
        chk("bp_hold_tag", 32'(bus.o_res_tag), 32'd0);
        chk("bp_hold_data", 32'(bus.o_res_data), 32'h3);
        bus.i_res_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_res_ready = 1'b0;
        chk("bp_pop1_tag", 32'(bus.o_res_tag), 32'd1);
        chk("bp_pop1_ready", 32'(bus.o_cmd_ready), 32'd1);
        send(OP_PASS_B, 8'h00, 8'h33, 4, ok);
        chk("bp_third_accept", 32'(ok), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        bus.i_res_ready = 1'b1;
        chk("bp_order1_tag", 32'(bus.o_res_tag), 32'd1);
        chk("bp_order1_data", 32'(bus.o_res_data), 32'h11);
        @(posedge clk); #1;
        chk("bp_order2_tag", 32'(bus.o_res_tag), 32'd2);
        chk("bp_order2_data", 32'(bus.o_res_data), 32'h33);
        @(posedge clk); #1;
        chk("bp_drained", 32'(bus.o_res_valid), 32'd0);

        // Tag wrap over 257 commands
        do_reset();
        bus.i_res_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send(OP_PASS_B, 8'h00, 8'(i * 3), 10, ok);
            wait_valid(lat);
            chk($sformatf("wrap_tag_%0d", i), 32'(bus.o_res_tag), 32'(i % 256));
            chk($sformatf("wrap_data_%0d", i), 32'(bus.o_res_data), 32'((i * 3) % 256));
        end
        @(posedge clk); #1;

        // Reset during DRIVE with one result buffered
        do_reset();
        bus.i_res_ready = 1'b0;
        send(OP_PASS_A, 8'h77, 8'h00, 10, ok);
        wait_valid(lat);
        chk("mid_rst_buffered", 32'(bus.o_res_valid), 32'd1);
        send(OP_PASS_A, 8'h88, 8'h00, 10, ok);
        chk("mid_rst_in_drive", 32'(bus.o_busy), 32'd1);
        #1 rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(bus.o_res_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.o_cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.o_cmd_ready), 32'd1);
        chk("post_rst_valid", 32'(bus.o_res_valid), 32'd0);
        chk("post_rst_tag", 32'(bus.o_res_tag), 32'd0);
        bus.i_res_ready = 1'b1;
        send(OP_PASS_B, 8'h00, 8'h44, 10, ok);
        wait_valid(lat);
        chk("post_rst_first_tag", 32'(bus.o_res_tag), 32'd0);
        chk("post_rst_first_data", 32'(bus.o_res_data), 32'h44);
        @(posedge clk); #1;

        // Faulty ALU result: checker flags it (only when built in) and the flag is sticky
        force_bad = 1'b1;
        send(OP_PASS_A, 8'h01, 8'h00, 10, ok);
        wait_valid(lat);
        force_bad = 1'b0;
        chk("bad_alu_data", 32'(bus.o_res_data), 32'h0);
        chk("mismatch_set", 32'(bus.o_mismatch), 32'(CHECK_EN));
        send(OP_XOR, 8'h0F, 8'hF0, 10, ok);
        wait_valid(lat);
        chk("good_after_bad_data", 32'(bus.o_res_data), 32'hFF);
        chk("mismatch_sticky", 32'(bus.o_mismatch), 32'(CHECK_EN));
        do_reset();
        chk("mismatch_cleared", 32'(bus.o_mismatch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
